// File: rtl/expr_recognizer.sv
// Streaming recognizer for ASCII arithmetic expressions: multi-digit operands, + - * /, nested parens.
// Optional feature: define SPACE_SKIP_EN to let 0x20 act as a separator instead of an illegal char.
module expr_recognizer #(
  parameter int MAX_DEPTH  = 7,
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 8,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               restart,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   char_cnt
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DCNT_W-1:0]  DCNT_MAX  = DCNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {S_OPND, S_NUM, S_CLOSE, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sp_q, sp_d;
  logic               out_q, out_d;
  logic               err_q, err_d;

  logic is_digit, is_op, is_lpar, is_rpar, is_skip;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_op    = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
  assign is_lpar  = (in == 8'h28);
  assign is_rpar  = (in == 8'h29);
`ifdef SPACE_SKIP_EN
  assign is_skip  = (in == 8'h20);
`else
  assign is_skip  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    if (restart) begin
      state_d = S_OPND;
      depth_d = '0;
      dcnt_d  = '0;
      cnt_d   = '0;
      sp_d    = 1'b0;
    end else if (in_valid) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        S_OPND: begin
          if (is_digit) begin
            state_d = S_NUM;
            dcnt_d  = DCNT_W'(1);
            sp_d    = 1'b0;
          end else if (is_lpar) begin
            if (depth_q == DEPTH_MAX) state_d = S_ERR;
            else depth_d = depth_q + DEPTH_W'(1);
          end else if (!is_skip) begin
            state_d = S_ERR;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            // a space already ended this number, so another digit cannot extend it
            if (dcnt_q == DCNT_MAX || sp_q) state_d = S_ERR;
            else dcnt_d = dcnt_q + DCNT_W'(1);
          end else if (is_op) begin
            state_d = S_OPND;
          end else if (is_rpar) begin
            if (depth_q == '0) state_d = S_ERR;
            else begin
              state_d = S_CLOSE;
              depth_d = depth_q - DEPTH_W'(1);
            end
          end else if (is_skip) begin
            sp_d = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_CLOSE: begin
          if (is_op) begin
            state_d = S_OPND;
          end else if (is_rpar) begin
            if (depth_q == '0) state_d = S_ERR;
            else depth_d = depth_q - DEPTH_W'(1);
          end else if (!is_skip) begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
        end
      endcase
    end
    out_d = ((state_d == S_NUM) || (state_d == S_CLOSE)) && (depth_d == '0);
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_OPND;
      depth_q <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      sp_q    <= 1'b0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign out      = out_q;
  assign err      = err_q;
  assign depth    = depth_q;
  assign char_cnt = cnt_q;

endmodule

// File: tb/tb_expr_recognizer.sv
// Scoreboarded bench for expr_recognizer; a behavioural model queues the expected outputs per driven cycle.
// Scenario tests add fixed expectations; build with SPACE_SKIP_EN defined to exercise space skipping.
module tb_expr_recognizer;
  localparam int MAX_DEPTH  = 7;
  localparam int MAX_DIGITS = 4;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int M_OPND = 0, M_NUM = 1, M_CLOSE = 2, M_ERR = 3;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       restart = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'h00;
  logic       out_w, err_w;
  logic [2:0] depth_w;
  logic [7:0] cnt_w;

  expr_recognizer #(.MAX_DEPTH(MAX_DEPTH), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
    .out(out_w), .err(err_w), .depth(depth_w), .char_cnt(cnt_w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       o;
    logic       e;
    logic [2:0] d;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;

  int m_state, m_depth, m_dcnt, m_cnt;
  bit m_sp;

  task automatic model_reset();
    m_state = M_OPND; m_depth = 0; m_dcnt = 0; m_cnt = 0; m_sp = 0;
  endtask

  // Character-first reference model of the grammar
  task automatic model_step(input bit v, input logic [7:0] ch, input bit rs);
    bit dig, op;
    if (rs) begin model_reset(); return; end
    if (!v) return;
    if (m_cnt < CNT_MAX) m_cnt++;
    if (m_state == M_ERR) return;
    dig = (ch >= 8'h30) && (ch <= 8'h39);
    op  = (ch == "+") || (ch == "-") || (ch == "*") || (ch == "/");
`ifdef SPACE_SKIP_EN
    if (ch == 8'h20) begin
      if (m_state == M_NUM) m_sp = 1;
      return;
    end
`endif
    if (dig) begin
      if (m_state == M_OPND) begin m_state = M_NUM; m_dcnt = 1; m_sp = 0; end
      else if (m_state == M_NUM && !m_sp && m_dcnt < MAX_DIGITS) m_dcnt++;
      else m_state = M_ERR;
    end else if (op) begin
      if (m_state == M_NUM || m_state == M_CLOSE) m_state = M_OPND;
      else m_state = M_ERR;
    end else if (ch == "(") begin
      if (m_state == M_OPND && m_depth < MAX_DEPTH) m_depth++;
      else m_state = M_ERR;
    end else if (ch == ")") begin
      if ((m_state == M_NUM || m_state == M_CLOSE) && m_depth > 0) begin
        m_depth--; m_state = M_CLOSE;
      end else m_state = M_ERR;
    end else begin
      m_state = M_ERR;
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.o = ((m_state == M_NUM) || (m_state == M_CLOSE)) && (m_depth == 0);
    e.e = (m_state == M_ERR);
    e.d = 3'(m_depth);
    e.c = 8'(m_cnt);
    return e;
  endfunction

  // Scoreboard: compare DUT outputs 1 time unit after each edge that consumed queued stimulus
  always @(posedge clk) begin
    if (exp_q.size() != 0) begin
      #1;
      mon_e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d: in=%h v=%0b rs=%0b -> out=%0b err=%0b depth=%0d cnt=%0d",
               n_txn, in_ch, in_valid, restart, out_w, err_w, depth_w, cnt_w);
      n_checks++;
      if (out_w !== mon_e.o) begin n_fail++; $display("FAIL sb_out txn %0d: got %0b want %0b", n_txn, out_w, mon_e.o); end
      n_checks++;
      if (err_w !== mon_e.e) begin n_fail++; $display("FAIL sb_err txn %0d: got %0b want %0b", n_txn, err_w, mon_e.e); end
      n_checks++;
      if (depth_w !== mon_e.d) begin n_fail++; $display("FAIL sb_depth txn %0d: got %0d want %0d", n_txn, depth_w, mon_e.d); end
      n_checks++;
      if (cnt_w !== mon_e.c) begin n_fail++; $display("FAIL sb_cnt txn %0d: got %0d want %0d", n_txn, cnt_w, mon_e.c); end
    end
  end

  // One clock of stimulus; returns 2 units after the consuming edge with inputs idle
  task automatic cycle(input bit v, input logic [7:0] ch, input bit rs);
    @(negedge clk);
    in_valid = v; in_ch = ch; restart = rs;
    model_step(v, ch, rs);
    exp_q.push_back(model_view());
    @(posedge clk);
    #2;
    in_valid = 1'b0; restart = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], 1'b0);
  endtask

  // Pulse clr_n between edges; outputs must clear before any clock edge
  task automatic mid_reset(input string tag);
    clr_n = 1'b0;
    #1;
    n_checks++;
    if (out_w !== 1'b0) begin n_fail++; $display("FAIL %s_rst_out: got %0b want 0", tag, out_w); end
    n_checks++;
    if (err_w !== 1'b0) begin n_fail++; $display("FAIL %s_rst_err: got %0b want 0", tag, err_w); end
    n_checks++;
    if (depth_w !== 3'd0) begin n_fail++; $display("FAIL %s_rst_depth: got %0d want 0", tag, depth_w); end
    n_checks++;
    if (cnt_w !== 8'd0) begin n_fail++; $display("FAIL %s_rst_cnt: got %0d want 0", tag, cnt_w); end
    model_reset();
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_checks++;
    if ({out_w, err_w, depth_w, cnt_w} !== 13'd0) begin
      n_fail++; $display("FAIL reset_state: got out=%0b err=%0b depth=%0d cnt=%0d want all 0", out_w, err_w, depth_w, cnt_w);
    end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_basic();
    string s;
    logic  exp_o [4];
    s = "0*1+";
    exp_o = '{1'b1, 1'b0, 1'b1, 1'b0};
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, s[i], 1'b0);
      n_checks++;
      if (out_w !== exp_o[i]) begin n_fail++; $display("FAIL basic_out[%0d]: got %0b want %0b", i, out_w, exp_o[i]); end
      n_checks++;
      if (err_w !== 1'b0) begin n_fail++; $display("FAIL basic_err[%0d]: got %0b want 0", i, err_w); end
    end
    n_checks++;
    if (cnt_w !== 8'd4) begin n_fail++; $display("FAIL basic_cnt: got %0d want 4", cnt_w); end
    cycle(1'b0, "5", 1'b0);
    n_checks++;
    if (out_w !== 1'b0 || cnt_w !== 8'd4) begin n_fail++; $display("FAIL hold_idle: got out=%0b cnt=%0d want 0/4", out_w, cnt_w); end
  endtask

  task automatic test_nested();
    string s;
    logic  exp_o [8];
    int    peak;
    cycle(1'b0, 8'h00, 1'b1);
    send_str("(12");
    n_checks++;
    if (depth_w !== 3'd1) begin n_fail++; $display("FAIL nested_pre_depth: got %0d want 1", depth_w); end
    mid_reset("nested");
    s = "(12+3)*4";
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, s[i], 1'b0);
      if (int'(depth_w) > peak) peak = int'(depth_w);
      n_checks++;
      if (out_w !== exp_o[i]) begin n_fail++; $display("FAIL nested_out[%0d]: got %0b want %0b", i, out_w, exp_o[i]); end
    end
    n_checks++;
    if (peak != 1) begin n_fail++; $display("FAIL nested_peak: got %0d want 1", peak); end
    n_checks++;
    if (depth_w !== 3'd0 || cnt_w !== 8'd8) begin n_fail++; $display("FAIL nested_final: got depth=%0d cnt=%0d want 0/8", depth_w, cnt_w); end
  endtask

  task automatic test_digits();
    string s;
    s = "123456";
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, s[i], 1'b0);
      if (i == 3) begin
        n_checks++;
        if (out_w !== 1'b1 || err_w !== 1'b0) begin n_fail++; $display("FAIL digits_4th: got out=%0b err=%0b want 1/0", out_w, err_w); end
      end
      if (i >= 4) begin
        n_checks++;
        if (err_w !== 1'b1 || out_w !== 1'b0) begin n_fail++; $display("FAIL digits_over[%0d]: got out=%0b err=%0b want 0/1", i, out_w, err_w); end
      end
    end
    n_checks++;
    if (cnt_w !== 8'd6) begin n_fail++; $display("FAIL digits_cnt: got %0d want 6", cnt_w); end
  endtask

  task automatic test_depth();
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, "(", 1'b0);
      if (i == 6) begin
        n_checks++;
        if (depth_w !== 3'd7 || err_w !== 1'b0) begin n_fail++; $display("FAIL depth_max: got depth=%0d err=%0b want 7/0", depth_w, err_w); end
      end
    end
    n_checks++;
    if (err_w !== 1'b1 || depth_w !== 3'd7) begin n_fail++; $display("FAIL depth_over: got depth=%0d err=%0b want 7/1", depth_w, err_w); end
    mid_reset("depth");
    cycle(1'b1, ")", 1'b0);
    n_checks++;
    if (err_w !== 1'b1 || depth_w !== 3'd0) begin n_fail++; $display("FAIL depth_under: got depth=%0d err=%0b want 0/1", depth_w, err_w); end
  endtask

  task automatic test_restart();
    cycle(1'b0, 8'h00, 1'b1);
    send_str("3+(");
    n_checks++;
    if (depth_w !== 3'd1 || cnt_w !== 8'd3) begin n_fail++; $display("FAIL restart_pre: got depth=%0d cnt=%0d want 1/3", depth_w, cnt_w); end
    cycle(1'b1, "5", 1'b1);
    n_checks++;
    if ({out_w, err_w, depth_w, cnt_w} !== 13'd0) begin
      n_fail++; $display("FAIL restart_clear: got out=%0b err=%0b depth=%0d cnt=%0d want all 0", out_w, err_w, depth_w, cnt_w);
    end
    cycle(1'b1, "7", 1'b0);
    n_checks++;
    if (out_w !== 1'b1 || cnt_w !== 8'd1) begin n_fail++; $display("FAIL restart_after: got out=%0b cnt=%0d want 1/1", out_w, cnt_w); end
    mid_reset("restart");
  endtask

  task automatic test_space();
    string s;
    s = "1 + 2";
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, s[i], 1'b0);
`ifndef SPACE_SKIP_EN
      if (i == 1) begin
        n_checks++;
        if (err_w !== 1'b1) begin n_fail++; $display("FAIL space_illegal: got err=%0b want 1", err_w); end
      end
`endif
    end
`ifdef SPACE_SKIP_EN
    n_checks++;
    if (out_w !== 1'b1 || err_w !== 1'b0 || cnt_w !== 8'd5) begin
      n_fail++; $display("FAIL space_skip: got out=%0b err=%0b cnt=%0d want 1/0/5", out_w, err_w, cnt_w);
    end
    cycle(1'b0, 8'h00, 1'b1);
    send_str("1 2");
    n_checks++;
    if (err_w !== 1'b1) begin n_fail++; $display("FAIL space_split_num: got err=%0b want 1", err_w); end
`endif
  endtask

  task automatic test_saturation();
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 260; i++) cycle(1'b1, "x", 1'b0);
    n_checks++;
    if (cnt_w !== 8'd255 || err_w !== 1'b1) begin n_fail++; $display("FAIL cnt_saturate: got cnt=%0d err=%0b want 255/1", cnt_w, err_w); end
  endtask

  task automatic test_back_to_back();
    string pool;
    int    r;
    pool = "0123456789+-*/(((()))) x";
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) cycle(1'b1, pool[$urandom_range(0, pool.len() - 1)], 1'b1);
      else if (r < 16) cycle(1'b0, pool[$urandom_range(0, pool.len() - 1)], 1'b0);
      else cycle(1'b1, pool[$urandom_range(0, pool.len() - 1)], 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_nested();
    test_digits();
    test_depth();
    test_restart();
    test_space();
    test_saturation();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
